// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing types and default 800x480 panel constants, used by the
// generator and by the capture-side line/frame counters.
package lcd_timing_pkg;

    localparam int CNT_W = 16;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BP     = 29;

    typedef enum logic [1:0] {
        REG_SYNC,
        REG_BP,
        REG_ACTIVE,
        REG_FP
    } region_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Sync/pixel-position bundle between the timing generator (master) and its
// consumers: LCD pins, overlay logic, capture-side counters (slave).
interface lcd_timing_gen_if;
    import lcd_timing_pkg::*;

    logic             ENABLE;
    logic             HS;
    logic             VS;
    logic             DE;
    logic [CNT_W-1:0] X;
    logic [CNT_W-1:0] Y;
    logic             FRAME_START;
    logic             BUSY;

    modport master (
        input  ENABLE,
        output HS, VS, DE, X, Y, FRAME_START, BUSY
    );

    modport slave (
        output ENABLE,
        input  HS, VS, DE, X, Y, FRAME_START, BUSY
    );

endinterface

// File: rtl/lcd_axis_counter.sv
// One timing axis: a wrapping position counter split into SYNC/BP/ACTIVE/FP
// regions, with terminal-count flag and offset within the active region.
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int SYNC   = 1,
    parameter int BP     = 1,
    parameter int ACTIVE = 1,
    parameter int FP     = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             step,
    output logic [CNT_W-1:0] cnt,
    output region_t          region,
    output logic             last,
    output logic [CNT_W-1:0] pos
);

    localparam logic [CNT_W-1:0] BP_START  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] FP_START  = CNT_W'(SYNC + BP + ACTIVE);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SYNC + BP + ACTIVE + FP - 1);

    generate
        if (SYNC < 1 || BP < 1 || ACTIVE < 1 || FP < 1) begin : g_bad_timing
            $error("lcd_axis_counter: every timing parameter must be >= 1");
        end
        if (SYNC + BP + ACTIVE + FP > (1 << CNT_W)) begin : g_bad_length
            $error("lcd_axis_counter: axis length does not fit the counter");
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        region = REG_FP;
        if (cnt < BP_START) begin
            region = REG_SYNC;
        end else if (cnt < ACT_START) begin
            region = REG_BP;
        end else if (cnt < FP_START) begin
            region = REG_ACTIVE;
        end
    end

    assign last = (cnt == LAST_CNT);
    assign pos  = (region == REG_ACTIVE) ? cnt - ACT_START : '0;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator: HS/VS/DE and active pixel coordinates from one pixel
// clock, with whole-frame start/stop under ENABLE. Outputs lag (h,v) by one clock.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic              CLK,
    input  logic              RESET,
    lcd_timing_gen_if.master  bus
);

    state_t           state;
    logic             run;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_pos, v_pos;
    region_t          h_region, v_region;
    logic             h_last, v_last;
    logic             v_active;
    logic             de_next;

    assign run = (state == ST_RUN);

    // Counters sit at 0 throughout IDLE so the first RUN cycle is h=0, v=0.
    lcd_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_axis (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr    (!run),
        .step   (run),
        .cnt    (h_cnt),
        .region (h_region),
        .last   (h_last),
        .pos    (h_pos)
    );

    lcd_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_axis (
        .CLK    (CLK),
        .RESET  (RESET),
        .clr    (!run),
        .step   (run && h_last),
        .cnt    (v_cnt),
        .region (v_region),
        .last   (v_last),
        .pos    (v_pos)
    );

    assign v_active = run && (v_region == REG_ACTIVE);
    assign de_next  = v_active && (h_region == REG_ACTIVE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state           <= ST_IDLE;
            bus.HS          <= 1'b1;
            bus.VS          <= 1'b1;
            bus.DE          <= 1'b0;
            bus.X           <= '0;
            bus.Y           <= '0;
            bus.FRAME_START <= 1'b0;
            bus.BUSY        <= 1'b0;
        end else begin
            // ENABLE only matters when idle or on the final clock of a frame.
            case (state)
                ST_IDLE: if (bus.ENABLE) state <= ST_RUN;
                ST_RUN:  if (h_last && v_last && !bus.ENABLE) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase

            bus.HS          <= !(run && (h_region == REG_SYNC));
            bus.VS          <= !(run && (v_region == REG_SYNC));
            bus.DE          <= de_next;
            bus.X           <= de_next ? h_pos : '0;
            bus.Y           <= v_active ? v_pos : '0;
            bus.FRAME_START <= run && (h_cnt == '0) && (v_cnt == '0);
            bus.BUSY        <= run;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a small 15x8 raster (120 clocks/frame):
// start, back-to-back frames, clean stop, restart from idle, async reset.
module tb_lcd_timing_gen;

    localparam int HS_W = 2, HB = 3, HA = 8, HF = 2;
    localparam int VS_W = 1, VB = 2, VA = 4, VF = 1;
    localparam int L = 15, F = 8, FRAME = 120;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    // Receiver-side accumulators
    logic prev_hs, prev_de;
    int   last_rise, burst, de_tot, rises_vs, hs_low, vs_low, fs_cnt;

    lcd_timing_gen_if bus ();

    lcd_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS_W), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS_W), .V_BP (VB)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_acc();
        prev_hs = 1'b1; prev_de = 1'b0; last_rise = -100; burst = 0;
        de_tot = 0; rises_vs = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
    endtask

    // Expected outputs for frame clock k, derived from raster position.
    task automatic check_pos(input int k);
        int kk, h, v;
        logic e_hs, e_vs, e_de, v_act;
        int e_x, e_y;
        kk    = k % FRAME;
        h     = kk % L;
        v     = kk / L;
        e_hs  = !(h < HS_W);
        e_vs  = !(v < VS_W);
        v_act = (v >= VS_W + VB) && (v < VS_W + VB + VA);
        e_de  = v_act && (h >= HS_W + HB) && (h < HS_W + HB + HA);
        e_x   = e_de ? h - (HS_W + HB) : 0;
        e_y   = v_act ? v - (VS_W + VB) : 0;
        chk($sformatf("hs k=%0d", k), {31'b0, bus.HS}, {31'b0, e_hs});
        chk($sformatf("vs k=%0d", k), {31'b0, bus.VS}, {31'b0, e_vs});
        chk($sformatf("de k=%0d", k), {31'b0, bus.DE}, {31'b0, e_de});
        chk($sformatf("x k=%0d", k), {16'b0, bus.X}, 32'(e_x));
        chk($sformatf("y k=%0d", k), {16'b0, bus.Y}, 32'(e_y));
        chk($sformatf("fs k=%0d", k), {31'b0, bus.FRAME_START}, {31'b0, (kk == 0)});
        chk($sformatf("busy k=%0d", k), {31'b0, bus.BUSY}, 32'd1);

        if (!prev_hs && bus.HS) begin
            last_rise = k;
            if (bus.VS) rises_vs++;
        end
        if (!prev_de && bus.DE) chk($sformatf("de_after_hs_rise k=%0d", k), 32'(k - last_rise), 32'd3);
        if (bus.DE) begin burst++; de_tot++; end
        if (prev_de && !bus.DE) begin
            chk($sformatf("de_burst k=%0d", k), 32'(burst), 32'd8);
            burst = 0;
        end
        if (!bus.HS) hs_low++;
        if (!bus.VS) vs_low++;
        if (bus.FRAME_START) fs_cnt++;
        prev_hs = bus.HS;
        prev_de = bus.DE;

        if (kk == FRAME - 1) begin
            chk($sformatf("frame_de_clocks k=%0d", k), 32'(de_tot), 32'd32);
            chk($sformatf("frame_hs_rises_vs_high k=%0d", k), 32'(rises_vs), 32'(F - VS_W));
            chk($sformatf("frame_hs_low k=%0d", k), 32'(hs_low), 32'(HS_W * F));
            chk($sformatf("frame_vs_low k=%0d", k), 32'(vs_low), 32'(L * VS_W));
            chk($sformatf("frame_starts k=%0d", k), 32'(fs_cnt), 32'd1);
            de_tot = 0; rises_vs = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
        end
    endtask

    task automatic sweep(input int first, input int last, input int drop_at);
        for (int k = first; k <= last; k++) begin
            if (k == drop_at) bus.ENABLE = 1'b0;
            step();
            check_pos(k);
        end
    endtask

    initial begin
        int fs_idle;
        bus.ENABLE = 1'b0;
        reset_acc();

        // Reset state
        repeat (3) step();
        chk("rst_hs", {31'b0, bus.HS}, 32'd1);
        chk("rst_vs", {31'b0, bus.VS}, 32'd1);
        chk("rst_de", {31'b0, bus.DE}, 32'd0);
        chk("rst_x", {16'b0, bus.X}, 32'd0);
        chk("rst_y", {16'b0, bus.Y}, 32'd0);
        chk("rst_fs", {31'b0, bus.FRAME_START}, 32'd0);
        chk("rst_busy", {31'b0, bus.BUSY}, 32'd0);

        // Three back-to-back frames; ENABLE drops at clock 50 of the third
        bus.ENABLE = 1'b1;
        rst = 1'b0;
        step();
        chk("start_busy_lag", {31'b0, bus.BUSY}, 32'd0);
        sweep(0, 3 * FRAME - 1, 2 * FRAME + 50);

        // Third frame completed; generator is now idle
        fs_idle = 0;
        for (int i = 0; i < 130; i++) begin
            step();
            chk($sformatf("idle_busy i=%0d", i), {31'b0, bus.BUSY}, 32'd0);
            chk($sformatf("idle_hs i=%0d", i), {31'b0, bus.HS}, 32'd1);
            chk($sformatf("idle_vs i=%0d", i), {31'b0, bus.VS}, 32'd1);
            chk($sformatf("idle_de i=%0d", i), {31'b0, bus.DE}, 32'd0);
            if (bus.FRAME_START) fs_idle++;
        end
        chk("idle_frame_starts", 32'(fs_idle), 32'd0);

        // Re-enable from idle: registered outputs follow one clock after RUN
        reset_acc();
        bus.ENABLE = 1'b1;
        step();
        chk("reen_fs_lag", {31'b0, bus.FRAME_START}, 32'd0);
        chk("reen_hs_lag", {31'b0, bus.HS}, 32'd1);
        chk("reen_busy_lag", {31'b0, bus.BUSY}, 32'd0);
        sweep(0, 55, -1);
        chk("pre_rst_de", {31'b0, bus.DE}, 32'd1);
        chk("pre_rst_x", {16'b0, bus.X}, 32'd5);

        // Asynchronous reset between clock edges
        rst = 1'b1;
        #1;
        chk("arst_hs", {31'b0, bus.HS}, 32'd1);
        chk("arst_vs", {31'b0, bus.VS}, 32'd1);
        chk("arst_de", {31'b0, bus.DE}, 32'd0);
        chk("arst_x", {16'b0, bus.X}, 32'd0);
        chk("arst_y", {16'b0, bus.Y}, 32'd0);
        chk("arst_busy", {31'b0, bus.BUSY}, 32'd0);
        #2;
        rst = 1'b0;

        // Clean full frame after release with ENABLE held
        reset_acc();
        step();
        chk("post_rst_busy_lag", {31'b0, bus.BUSY}, 32'd0);
        chk("post_rst_hs_lag", {31'b0, bus.HS}, 32'd1);
        sweep(0, FRAME - 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
